// File: rtl/hlcp_fault_pkg.sv
// Shared constants, types and frame-byte helper for the HLCP fault collector.
// Sticky vector layout: channel n occupies bits [n*CH_W +: CH_W], holding
// short[5:0] at SHORT_OFS, open[5:0] at OPEN_OFS, then overheat, overvoltage,
// undervoltage at OH_OFS/OV_OFS/UV_OFS.
package hlcp_fault_pkg;

  localparam int unsigned NUM_CH         = 4;
  localparam int unsigned LED_W          = 6;
  localparam int unsigned CH_W           = 15;
  localparam int unsigned FLT_W          = NUM_CH * CH_W;

  localparam int unsigned SHORT_OFS      = 0;
  localparam int unsigned OPEN_OFS       = 6;
  localparam int unsigned OH_OFS         = 12;
  localparam int unsigned OV_OFS         = 13;
  localparam int unsigned UV_OFS         = 14;

  localparam int unsigned FRAME_LEN_BASE = 13;
  localparam int unsigned FRAME_LEN_CHK  = 14;
  localparam int unsigned IDX_W          = 4;

  localparam int unsigned HDR_ANY_BIT    = 7;
  localparam int unsigned HDR_MASK_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNAP = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Frame bytes 0..12 built from a sticky snapshot; indices beyond 12 give 0.
  function automatic logic [7:0] frame_byte(input logic [FLT_W-1:0] v,
                                            input logic [IDX_W-1:0] idx);
    logic [CH_W-1:0]   ch;
    logic [NUM_CH-1:0] mask;
    frame_byte = 8'h00;
    ch         = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      mask[n] = |v[n*CH_W +: CH_W];
    end
    case (idx)
      4'd1, 4'd2, 4'd3:    ch = v[0*CH_W +: CH_W];
      4'd4, 4'd5, 4'd6:    ch = v[1*CH_W +: CH_W];
      4'd7, 4'd8, 4'd9:    ch = v[2*CH_W +: CH_W];
      4'd10, 4'd11, 4'd12: ch = v[3*CH_W +: CH_W];
      default:             ch = '0;
    endcase
    case (idx)
      4'd0: begin
        frame_byte[HDR_ANY_BIT]             = |v;
        frame_byte[HDR_MASK_LSB +: NUM_CH]  = mask;
      end
      4'd1, 4'd4, 4'd7, 4'd10: frame_byte = {2'b00, ch[SHORT_OFS +: LED_W]};
      4'd2, 4'd5, 4'd8, 4'd11: frame_byte = {2'b00, ch[OPEN_OFS +: LED_W]};
      4'd3, 4'd6, 4'd9, 4'd12: frame_byte = {5'b00000, ch[UV_OFS], ch[OV_OFS], ch[OH_OFS]};
      default:                 frame_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/hlcp_fault_debounce.sv
// Single-bit 2-flop synchroniser followed by a stability counter.
// Ports: clk, rst_n (async active-low), raw (asynchronous input),
//        deb (debounced level, changes after DEB_CYCLES stable samples).
module hlcp_fault_debounce #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned DEB_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [DEB_W-1:0] cnt_q;

  // Synchronise, then accept a new level only after it has been seen steadily.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      deb     <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      if (sync2_q == deb) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        deb   <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + DEB_W'(1);
      end
    end
  end

endmodule

// File: rtl/hlcp_fault_collector.sv
// Per-slave fault collector: debounces 60 raw fault bits into sticky
// registers and streams a snapshot as a byte frame on a read request,
// clearing the reported bits when the frame completes.
// Optional macro HLCP_FAULT_CHKSUM_EN appends an XOR checksum byte.
// Ports: sys_clk, sys_resetb (async active-low); raw per-channel fault
//        flags; rd_start_i/abort_i from the protocol engine; byte_o,
//        byte_valid_o, byte_ready_i handshake; rd_done_o pulse;
//        fault_irq_o (registered OR of sticky bits).
module hlcp_fault_collector
  import hlcp_fault_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned DEB_W      = 8
) (
  input  logic       sys_clk,
  input  logic       sys_resetb,
  input  logic [5:0] short_i_0,
  input  logic [5:0] short_i_1,
  input  logic [5:0] short_i_2,
  input  logic [5:0] short_i_3,
  input  logic [5:0] open_i_0,
  input  logic [5:0] open_i_1,
  input  logic [5:0] open_i_2,
  input  logic [5:0] open_i_3,
  input  logic       overheat_0,
  input  logic       overheat_1,
  input  logic       overheat_2,
  input  logic       overheat_3,
  input  logic       overvoltage_0,
  input  logic       overvoltage_1,
  input  logic       overvoltage_2,
  input  logic       overvoltage_3,
  input  logic       undervoltage_0,
  input  logic       undervoltage_1,
  input  logic       undervoltage_2,
  input  logic       undervoltage_3,
  input  logic       rd_start_i,
  input  logic       abort_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic       rd_done_o,
  output logic       fault_irq_o
);

`ifdef HLCP_FAULT_CHKSUM_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_CHK;
  localparam logic [IDX_W-1:0] CHK_IDX = IDX_W'(FRAME_LEN_BASE);
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [FLT_W-1:0] raw_c;
  logic [FLT_W-1:0] deb_c;
  logic [FLT_W-1:0] clr_c;
  logic [FLT_W-1:0] sticky_q;
  logic [FLT_W-1:0] snap_q, snap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       byte_d;
  logic             valid_d;
  logic             done_d;
  state_e           state_q, state_d;

  // Pack the raw flags into the sticky-vector layout.
  assign raw_c[0*CH_W + SHORT_OFS +: LED_W] = short_i_0;
  assign raw_c[0*CH_W + OPEN_OFS  +: LED_W] = open_i_0;
  assign raw_c[0*CH_W + OH_OFS]             = overheat_0;
  assign raw_c[0*CH_W + OV_OFS]             = overvoltage_0;
  assign raw_c[0*CH_W + UV_OFS]             = undervoltage_0;
  assign raw_c[1*CH_W + SHORT_OFS +: LED_W] = short_i_1;
  assign raw_c[1*CH_W + OPEN_OFS  +: LED_W] = open_i_1;
  assign raw_c[1*CH_W + OH_OFS]             = overheat_1;
  assign raw_c[1*CH_W + OV_OFS]             = overvoltage_1;
  assign raw_c[1*CH_W + UV_OFS]             = undervoltage_1;
  assign raw_c[2*CH_W + SHORT_OFS +: LED_W] = short_i_2;
  assign raw_c[2*CH_W + OPEN_OFS  +: LED_W] = open_i_2;
  assign raw_c[2*CH_W + OH_OFS]             = overheat_2;
  assign raw_c[2*CH_W + OV_OFS]             = overvoltage_2;
  assign raw_c[2*CH_W + UV_OFS]             = undervoltage_2;
  assign raw_c[3*CH_W + SHORT_OFS +: LED_W] = short_i_3;
  assign raw_c[3*CH_W + OPEN_OFS  +: LED_W] = open_i_3;
  assign raw_c[3*CH_W + OH_OFS]             = overheat_3;
  assign raw_c[3*CH_W + OV_OFS]             = overvoltage_3;
  assign raw_c[3*CH_W + UV_OFS]             = undervoltage_3;

  for (genvar i = 0; i < FLT_W; i++) begin : g_deb
    hlcp_fault_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .DEB_W      (DEB_W)
    ) u_deb (
      .clk   (sys_clk),
      .rst_n (sys_resetb),
      .raw   (raw_c[i]),
      .deb   (deb_c[i])
    );
  end

`ifdef HLCP_FAULT_CHKSUM_EN
  function automatic logic [7:0] chksum(input logic [FLT_W-1:0] v);
    chksum = 8'h00;
    for (int unsigned i = 0; i < FRAME_LEN_BASE; i++) begin
      chksum = chksum ^ frame_byte(v, IDX_W'(i));
    end
  endfunction

  function automatic logic [7:0] next_byte(input logic [FLT_W-1:0] v,
                                           input logic [IDX_W-1:0] idx);
    next_byte = (idx == CHK_IDX) ? chksum(v) : frame_byte(v, idx);
  endfunction
`else
  function automatic logic [7:0] next_byte(input logic [FLT_W-1:0] v,
                                           input logic [IDX_W-1:0] idx);
    next_byte = frame_byte(v, idx);
  endfunction
`endif

  // Sticky fault bits; a new debounced fault wins over a same-cycle clear.
  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      sticky_q    <= '0;
      fault_irq_o <= 1'b0;
    end else begin
      sticky_q    <= (sticky_q & ~clr_c) | deb_c;
      fault_irq_o <= |sticky_q;
    end
  end

  // Frame FSM state and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      snap_q       <= '0;
      byte_o       <= 8'h00;
      byte_valid_o <= 1'b0;
      rd_done_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      byte_o       <= byte_d;
      byte_valid_o <= valid_d;
      rd_done_o    <= done_d;
    end
  end

  // Next-state and next-output logic. B0 is built straight from sticky in
  // SNAP so it is presented the cycle after the snapshot is taken.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    byte_d  = byte_o;
    valid_d = byte_valid_o;
    done_d  = 1'b0;
    clr_c   = '0;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (rd_start_i) state_d = ST_SNAP;
      end
      ST_SNAP: begin
        if (abort_i) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          snap_d  = sticky_q;
          idx_d   = '0;
          byte_d  = next_byte(sticky_q, IDX_W'(0));
          valid_d = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (abort_i) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else if (byte_valid_o && byte_ready_i) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            byte_d = next_byte(snap_q, idx_q + IDX_W'(1));
          end
        end
      end
      ST_DONE: begin
        clr_c   = snap_q;
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hlcp_fault_collector.sv
// Self-checking bench for hlcp_fault_collector: directed scenarios plus
// randomized fault patterns checked against a sticky/frame reference model.
module tb_hlcp_fault_collector;

`ifdef HLCP_FAULT_CHKSUM_EN
  localparam int FLEN = 14;
`else
  localparam int FLEN = 13;
`endif
  localparam int SETTLE = 40;

  logic        sys_clk;
  logic        sys_resetb;
  logic [59:0] raw_v;
  logic        rd_start_i, abort_i, byte_ready_i;
  logic [7:0]  byte_o;
  logic        byte_valid_o, rd_done_o, fault_irq_o;

  int          total, bad;
  logic [59:0] sticky_m;
  logic [7:0]  got [16];
  int          ngot, ndone;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  hlcp_fault_collector #(.DEB_CYCLES(16), .DEB_W(8)) dut (
    .sys_clk        (sys_clk),
    .sys_resetb     (sys_resetb),
    .short_i_0      (raw_v[0  +: 6]),
    .open_i_0       (raw_v[6  +: 6]),
    .overheat_0     (raw_v[12]),
    .overvoltage_0  (raw_v[13]),
    .undervoltage_0 (raw_v[14]),
    .short_i_1      (raw_v[15 +: 6]),
    .open_i_1       (raw_v[21 +: 6]),
    .overheat_1     (raw_v[27]),
    .overvoltage_1  (raw_v[28]),
    .undervoltage_1 (raw_v[29]),
    .short_i_2      (raw_v[30 +: 6]),
    .open_i_2       (raw_v[36 +: 6]),
    .overheat_2     (raw_v[42]),
    .overvoltage_2  (raw_v[43]),
    .undervoltage_2 (raw_v[44]),
    .short_i_3      (raw_v[45 +: 6]),
    .open_i_3       (raw_v[51 +: 6]),
    .overheat_3     (raw_v[57]),
    .overvoltage_3  (raw_v[58]),
    .undervoltage_3 (raw_v[59]),
    .rd_start_i     (rd_start_i),
    .abort_i        (abort_i),
    .byte_o         (byte_o),
    .byte_valid_o   (byte_valid_o),
    .byte_ready_i   (byte_ready_i),
    .rd_done_o      (rd_done_o),
    .fault_irq_o    (fault_irq_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected frame byte i for sticky state s (channel n = bits n*15..n*15+14).
  function automatic logic [7:0] exp_byte(input logic [59:0] s, input int i);
    logic [7:0] r;
    int ch, f, base;
    r = 8'h00;
    if (i == 0) begin
      r[7] = |s;
      for (int n = 0; n < 4; n++) r[n] = |s[n*15 +: 15];
    end else if (i <= 12) begin
      ch = (i - 1) / 3;
      f  = (i - 1) % 3;
      base = ch * 15;
      if (f == 0)      r = {2'b00, s[base +: 6]};
      else if (f == 1) r = {2'b00, s[base + 6 +: 6]};
      else             r = {5'b00000, s[base + 14], s[base + 13], s[base + 12]};
    end else if (i == 13) begin
      for (int k = 0; k < 13; k++) r = r ^ exp_byte(s, k);
    end
    return r;
  endfunction

  // Wait for the current raw pattern to pass the debouncer and latch.
  task automatic settle();
    repeat (SETTLE) @(negedge sys_clk);
    sticky_m = sticky_m | raw_v;
    check("irq_settle", 64'(fault_irq_o), 64'(|sticky_m));
  endtask

  // Issue one read; mode 0 always ready, 1 toggles every 3 cycles, 2 random.
  // abort_at >= 0 aborts once that many bytes have been accepted.
  task automatic do_read(input int mode, input int abort_at);
    logic [7:0] held;
    bit holding, aborted;
    holding = 0; aborted = 0; ngot = 0; ndone = 0;
    rd_start_i = 1'b1;
    @(negedge sys_clk);
    rd_start_i = 1'b0;
    check("lat_valid_n1", 64'(byte_valid_o), 64'd0);
    @(negedge sys_clk);
    check("lat_valid_n2", 64'(byte_valid_o), 64'd1);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (ngot == FLEN) break;
      if (rd_done_o) ndone++;
      if (holding) begin
        check("valid_held", 64'(byte_valid_o), 64'd1);
        check("byte_held", 64'(byte_o), 64'(held));
      end
      if (abort_at >= 0 && ngot == abort_at) begin
        byte_ready_i = 1'b0;
        abort_i = 1'b1;
        @(negedge sys_clk);
        abort_i = 1'b0;
        check("abort_valid", 64'(byte_valid_o), 64'd0);
        aborted = 1;
        break;
      end
      if (mode == 0)      byte_ready_i = 1'b1;
      else if (mode == 1) byte_ready_i = ((cyc / 3) % 2 == 0);
      else                byte_ready_i = 1'($urandom_range(0, 1));
      holding = 0;
      if (byte_valid_o && byte_ready_i) begin
        got[ngot] = byte_o;
        ngot++;
      end else if (byte_valid_o) begin
        holding = 1;
        held = byte_o;
      end
      @(negedge sys_clk);
    end
    byte_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rd_done_o) ndone++;
      @(negedge sys_clk);
    end
    if (aborted) begin
      check("abort_no_done", 64'(ndone), 64'd0);
      check("abort_nbytes", 64'(ngot), 64'(abort_at));
      for (int i = 0; i < ngot; i++) check("abort_byte", 64'(got[i]), 64'(exp_byte(sticky_m, i)));
    end else begin
      check("frame_complete", 64'(ngot), 64'(FLEN));
      check("done_pulses", 64'(ndone), 64'd1);
      for (int i = 0; i < ngot; i++) check($sformatf("byte%0d", i), 64'(got[i]), 64'(exp_byte(sticky_m, i)));
      sticky_m = raw_v;
    end
    check("irq_after_read", 64'(fault_irq_o), 64'(|sticky_m));
  endtask

  initial begin
    total = 0; bad = 0; sticky_m = '0;
    // Reset with every input high.
    sys_resetb = 1'b0; raw_v = '1;
    rd_start_i = 1'b1; abort_i = 1'b1; byte_ready_i = 1'b1;
    repeat (5) @(negedge sys_clk);
    check("rst_byte", 64'(byte_o), 64'd0);
    check("rst_valid", 64'(byte_valid_o), 64'd0);
    check("rst_done", 64'(rd_done_o), 64'd0);
    check("rst_irq", 64'(fault_irq_o), 64'd0);
    rd_start_i = 1'b0; abort_i = 1'b0; byte_ready_i = 1'b0;
    sys_resetb = 1'b1;
    @(negedge sys_clk);
    do_read(0, -1);
    // Restart clean with all faults removed.
    sys_resetb = 1'b0; raw_v = '0;
    repeat (3) @(negedge sys_clk);
    sys_resetb = 1'b1; sticky_m = '0;
    repeat (3) @(negedge sys_clk);

    // Debounce latency on short_i_0[0].
    raw_v[0] = 1'b1;
    repeat (19) @(negedge sys_clk);
    check("deb_irq_early", 64'(fault_irq_o), 64'd0);
    @(negedge sys_clk);
    check("deb_irq_rise", 64'(fault_irq_o), 64'd1);
    sticky_m[0] = 1'b1;
    raw_v[0] = 1'b0;
    settle();
    do_read(0, -1);
    check("deb_b0", 64'(got[0]), 64'h81);
    check("deb_b1", 64'(got[1]), 64'h01);

    // Short glitch on open_i_1[3] must not latch.
    raw_v[24] = 1'b1;
    repeat (10) @(negedge sys_clk);
    raw_v[24] = 1'b0;
    settle();
    do_read(2, -1);

    // Directed full frame.
    raw_v[30 +: 6] = 6'b101010;
    raw_v[36 +: 6] = 6'b101010;
    raw_v[58] = 1'b1;
    settle();
    do_read(0, -1);
    check("full_b0", 64'(got[0]), 64'h8C);
    check("full_b7", 64'(got[7]), 64'h2A);
    check("full_b8", 64'(got[8]), 64'h2A);
    check("full_b12", 64'(got[12]), 64'h02);
`ifdef HLCP_FAULT_CHKSUM_EN
    check("full_b13", 64'(got[13]), 64'h8E);
`endif
    // Fault still present: reappears, read under backpressure.
    do_read(1, -1);
    check("reread_b0", 64'(got[0]), 64'h8C);
    // Fault removed: sticky reports once more, then clears.
    raw_v = '0;
    settle();
    do_read(1, -1);
    check("removed_b0", 64'(got[0]), 64'h8C);
    do_read(0, -1);
    check("cleared_b0", 64'(got[0]), 64'h00);

    // Abort after B4, then a full read returns the same content.
    raw_v[5] = 1'b1; raw_v[50] = 1'b1;
    settle();
    do_read(0, 5);
    do_read(0, -1);

    // Randomized patterns, glitches, backpressure and aborts.
    for (int it = 0; it < 24; it++) begin
      int b;
      raw_v = 60'({$urandom, $urandom} & {$urandom, $urandom});
      settle();
      b = $urandom_range(0, 59);
      raw_v[b] = ~raw_v[b];
      repeat ($urandom_range(1, 12)) @(negedge sys_clk);
      raw_v[b] = ~raw_v[b];
      settle();
      if ($urandom_range(0, 3) == 0) do_read(int'($urandom_range(0, 2)), int'($urandom_range(0, 12)));
      do_read(int'($urandom_range(0, 2)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
